// File: rtl/collatz_pkg.sv
// Shared types and constants for the inverse-Collatz breadth-first enumerator.
// Holds the FSM state encoding, default widths and the node record.
package collatz_pkg;

  localparam int COLLATZ_WIDTH   = 8;
  localparam int COLLATZ_DEPTH_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EMIT,
    EXP_A,
    EXP_B,
    NEXT,
    DONE
  } state_t;

  typedef struct packed {
    logic [COLLATZ_WIDTH-1:0]   value;
    logic [COLLATZ_DEPTH_W-1:0] depth;
  } node_t;

  // Multiplicative inverse of 3 modulo 2^w: bit 0 plus every odd bit (...101011).
  // 3 * that pattern equals 2^(2m+1) + 1, which is 1 modulo 2^w.
  function automatic logic [63:0] inv3_mod2w(input int w);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 1; i < w && i < 64; i++) begin
      if (i % 2 == 1) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/collatz_pred.sv
// Combinational inverse-Collatz predecessors of v: the even child 2v and the
// odd child (v-1)/3, each with a flag saying whether the child is legal.
module collatz_pred
  import collatz_pkg::*;
#(
  parameter int WIDTH = COLLATZ_WIDTH
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] dbl,
  output logic             dbl_ok,
  output logic [WIDTH-1:0] div3,
  output logic             div3_ok
);

  localparam logic [WIDTH-1:0] INV3      = WIDTH'(inv3_mod2w(WIDTH));
  localparam logic [WIDTH-1:0] THIRD_MAX = WIDTH'(((64'd1 << WIDTH) - 64'd1) / 64'd3);

  logic [WIDTH-1:0] v_minus_1;
  logic [WIDTH-1:0] quo;
  logic             is_1mod3;

  assign dbl    = {v[WIDTH-2:0], 1'b0};
  assign dbl_ok = (v != '0) && !v[WIDTH-1];

  // Exact division by 3 via the modular inverse: the product lands at or below
  // (2^W-1)/3 exactly when v-1 is a multiple of 3. v=0 wraps, so it is excluded.
  assign v_minus_1 = v - WIDTH'(1);
  assign quo       = v_minus_1 * INV3;
  assign is_1mod3  = (v != '0) && (quo <= THIRD_MAX);

  assign div3    = quo;
  assign div3_ok = is_1mod3 && quo[0] && (quo > WIDTH'(1));

endmodule

// File: rtl/collatz_inverse_bfs.sv
// Breadth-first enumerator of the inverse-Collatz tree below a root, streaming
// (value, depth) nodes over valid/ready from an internal FIFO of pending nodes.
module collatz_inverse_bfs
  import collatz_pkg::*;
#(
  parameter int WIDTH      = COLLATZ_WIDTH,
  parameter int DEPTH_W    = COLLATZ_DEPTH_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   root,
  input  logic [DEPTH_W-1:0] max_depth,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_value,
  output logic [DEPTH_W-1:0] out_depth,
  output logic               done,
  output logic               overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0]   value;
    logic [DEPTH_W-1:0] depth;
  } bfs_node_t;

  state_t             state_q, state_d;
  bfs_node_t          cur_q, cur_d;
  logic [DEPTH_W-1:0] max_depth_q, max_depth_d;
  logic               overflow_q, overflow_d;

  bfs_node_t          mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic               push_req;
  logic               push_do;
  bfs_node_t          push_node;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;

  logic [WIDTH-1:0]   dbl;
  logic               dbl_ok;
  logic [WIDTH-1:0]   div3;
  logic               div3_ok;

  collatz_pred #(
    .WIDTH (WIDTH)
  ) u_pred (
    .v       (cur_q.value),
    .dbl     (dbl),
    .dbl_ok  (dbl_ok),
    .div3    (div3),
    .div3_ok (div3_ok)
  );

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    max_depth_d = max_depth_q;
    overflow_d  = overflow_q;
    push_req    = 1'b0;
    push_node   = '0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          push_req        = 1'b1;
          push_node.value = root;
          push_node.depth = '0;
          max_depth_d     = max_depth;
          overflow_d      = 1'b0;
          state_d         = FETCH;
        end
      end
      FETCH: begin
        pop     = 1'b1;
        cur_d   = mem_q[rd_ptr_q];
        state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          state_d = (cur_q.depth < max_depth_q) ? EXP_A : NEXT;
        end
      end
      EXP_A: begin
        push_req        = dbl_ok;
        push_node.value = dbl;
        push_node.depth = cur_q.depth + DEPTH_W'(1);
        state_d         = EXP_B;
      end
      EXP_B: begin
        push_req        = div3_ok;
        push_node.value = div3;
        push_node.depth = cur_q.depth + DEPTH_W'(1);
        state_d         = NEXT;
      end
      NEXT: begin
        state_d = fifo_empty ? DONE : FETCH;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A child offered to a full FIFO is lost; remember that for the consumer.
    push_do = push_req && !fifo_full;
    if (push_req && fifo_full) begin
      overflow_d = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_do) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      max_depth_q <= '0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      max_depth_q <= max_depth_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (push_do) begin
      mem_q[wr_ptr_q] <= push_node;
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign out_value = cur_q.value;
  assign out_depth = cur_q.depth;
  assign overflow  = overflow_q;

endmodule

// File: doc/collatz_inverse_bfs.md
Name: collatz_inverse_bfs

Overview:
- Sequential companion to the team's combinational forward Collatz step block; runs the map in the other direction.
- Given a root value, enumerates the inverse-Collatz tree breadth-first: every value whose forward trajectory reaches the root within max_depth steps.
- Streams each node out as (value, depth) over a valid/ready handshake, using an internal FIFO of pending nodes.
- Sits behind the chip's io_in/io_out wrapper, beside the forward step block.

Parameters:
- WIDTH, 8, bit width of node values; candidates ≥ 2^WIDTH are pruned.
- DEPTH_W, 4, bit width of depth fields and of max_depth.
- FIFO_DEPTH, 8, pending-node FIFO entries (power of 2).

Ports:
- clock  input  1  single clock, all state rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- root  input  WIDTH  tree root; latched on accepted start.
- max_depth  input  DEPTH_W  deepest level to emit; latched on accepted start.
- busy  output  1  high in every state except IDLE.
- out_valid  output  1  node available.
- out_ready  input  1  consumer accepts the node when out_valid and out_ready are both high.
- out_value  output  WIDTH  node value.
- out_depth  output  DEPTH_W  node distance from root.
- done  output  1  one-cycle pulse when enumeration completes.
- overflow  output  1  sticky: a child was dropped because the FIFO was full; cleared on accepted start.

Behaviour:
- Reset (async assert; release synchronous to clock): state=IDLE, FIFO empty, all outputs 0.
- IDLE:
  - start=1 pushes (root, 0) into the FIFO, latches max_depth, clears overflow, goes to FETCH.
  - start outside IDLE is ignored.
- FETCH (1 cycle): pop FIFO head into the current register, go to EMIT.
- EMIT:
  - out_valid=1 with the current value and depth.
  - out_value and out_depth stay stable until the handshake.
  - On handshake: go to EXP_A if depth < max_depth; otherwise go to NEXT.
  - Minimum latency from start to first out_valid is 2 cycles.
- EXP_A (1 cycle):
  - Candidate = 2v. Push (2v, d+1) when v != 0 and 2v < 2^WIDTH.
  - Go to EXP_B.
- EXP_B (1 cycle):
  - Candidate p = (v-1)/3. Valid only when v mod 3 == 1, p is odd and p > 1.
  - Excluding p = 1 breaks the 1→4→2→1 cycle.
  - If valid, push (p, d+1). Go to NEXT.
- Pushes and FIFO full:
  - At most one push per cycle.
  - A push into a full FIFO drops that candidate and sets overflow=1. Enumeration continues.
- NEXT (1 cycle): if the FIFO is empty, go to DONE; else go to FETCH.
- DONE: done=1 for exactly 1 cycle, then IDLE. busy falls in the same cycle the state enters IDLE.
- Ordering:
  - Strict BFS: all nodes at depth d are emitted before any node at depth d+1.
  - Within a parent, the 2v child precedes the (v-1)/3 child.
- Root 0: emits (0, 0) and has no children.
- max_depth 0: emits only the root.
- Reset mid-run aborts immediately. Emission state and FIFO contents are discarded; done does not pulse.

Decomposition:
- Shared package collatz_pkg:
  - state enum {IDLE, FETCH, EMIT, EXP_A, EXP_B, NEXT, DONE}.
  - WIDTH/DEPTH_W defaults.
  - node struct {value, depth}.
- One natural sub-module, collatz_pred:
  - Combinational; input v.
  - Outputs: dbl, dbl_ok, div3, div3_ok.
  - div3 uses a constant-divide-by-3 implementation; no generic divider.
- The FIFO is inline in this block: read/write pointers plus a count.

Test Plan:
- root=1, max_depth=3 -> emits (1,0),(2,1),(4,2),(8,3); done pulses 1 cycle after NEXT; overflow=0.
- root=16, max_depth=2 -> emits (16,0),(32,1),(5,1),(64,2),(10,2) in that order; overflow=0.
- root=200, max_depth=1 -> (200,0) only: 400 out of range, 200 mod 3=2. Then root=199 -> (199,0) only: 199 mod 3=1 but p=66 is even, and 398 is out of range.
- Backpressure: root=16, max_depth=2, out_ready low for 5 cycles in each EMIT -> out_value/out_depth stable while waiting; same sequence as above; no drops.
- FIFO_DEPTH=4, root=16, max_depth=15 -> overflow=1 by done; every emitted value forward-steps to its parent; depths non-decreasing; done pulses exactly once.
- reset_n asserted during EMIT of (32,1), then released -> out_valid=0, busy=0, done=0; next start with root=1 behaves exactly as the first scenario.
